// File: rtl/fifo_burst_reader.sv
// Burst read master for a single-clock FWFT FIFO: pops fixed-length bursts into a registered valid/ready stream.
// Optional FIFO_RD_TIMEOUT_EN adds a timed flush of residual words below the watermark.
module fifo_burst_reader #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  input  logic          fifo_progempty,
  output logic          fifo_rd_en,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic [15:0]   burst_cnt
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  if (BURST_LEN < 2 || BURST_LEN > 256 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("fifo_burst_reader: BURST_LEN or TIMEOUT out of range");
  end

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]   burst_cnt_q, burst_cnt_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          free;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        residual;
`endif

  always_comb begin
    free       = !m_valid_q || m_ready;
    fifo_rd_en = (state_q == BURST || state_q == FLUSH) && !fifo_empty && free;

    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;

    // Output stage: a pop always reloads, even in the same cycle as a handshake.
    if (fifo_rd_en) begin
      m_data_d  = fifo_dout;
      m_valid_d = 1'b1;
      m_last_d  = (state_q == FLUSH) || (beat_cnt_q == LAST_BEAT);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

`ifdef FIFO_RD_TIMEOUT_EN
    residual   = !fifo_empty && fifo_progempty;
    idle_cnt_d = 16'd0;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_progempty) begin
          state_d    = BURST;
          beat_cnt_d = '0;
`ifdef FIFO_RD_TIMEOUT_EN
        end else if (residual) begin
          if (idle_cnt_q == TIMEOUT_LAST) begin
            state_d    = FLUSH;
            beat_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
`endif
        end
      end
      BURST: begin
        if (fifo_rd_en) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            burst_cnt_d = burst_cnt_q + 16'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
`ifdef FIFO_RD_TIMEOUT_EN
      FLUSH: begin
        // Each flushed word is its own one-beat packet.
        if (fifo_rd_en) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
          if (beat_cnt_q == LAST_BEAT || !fifo_progempty) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (fifo_empty || !fifo_progempty) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
`endif
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      burst_cnt_q <= 16'd0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

`ifdef FIFO_RD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign burst_cnt = burst_cnt_q;
  assign busy      = (state_q != IDLE) || m_valid_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FWFT FIFO model, table of burst cases, scoreboard of expected beats,
// plus hand sequences for mid-burst reset and residual-word timeout.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_progempty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic [15:0]   burst_cnt;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_progempty(fifo_progempty),
    .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int       nwords;
    logic [3:0] ready_pat;
    bit       gap_en;
    int       exp_bursts;
    int       max_gap;
  } vec_t;

  beat_t         sb[$];
  logic [DW-1:0] fq[$];
  vec_t          vecs[4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int force_cnt = 0;
  int pops = 0;
  int beats = 0;
  int last_hs = -1;
  int max_gap = 0;
  bit rd_seen = 1'b0;
  bit mon_en = 1'b0;
  bit stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty     = (fq.size() == 0) || (force_cnt > 0);
    fifo_dout      = (fq.size() > 0) ? fq[0] : '0;
    fifo_progempty = (fq.size() < BL);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    if (force_cnt > 0) force_cnt--;
    update_fifo();
  endtask

  task automatic clear_mon();
    beats = 0; last_hs = -1; max_gap = 0; pops = 0; stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    m_ready = 1'b0;
    force_cnt = 0;
    fq.delete();
    sb.delete();
    update_fifo();
    repeat (2) step();
    check(m_valid == 1'b0, "rst_m_valid", int'(m_valid), 0);
    check(m_last == 1'b0, "rst_m_last", int'(m_last), 0);
    check(m_data == '0, "rst_m_data", int'(m_data), 0);
    check(burst_cnt == 16'd0, "rst_burst_cnt", int'(burst_cnt), 0);
    check(busy == 1'b0, "rst_busy", int'(busy), 0);
    check(fifo_rd_en == 1'b0, "rst_rd_en", int'(fifo_rd_en), 0);
    rst = 1'b0;
    clear_mon();
    mon_en = 1'b1;
  endtask

  task automatic load(input int n, input int base, input bit single, input bit push_sb);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      fq.push_back(DW'(base + i));
      if (push_sb) begin
        b.data = DW'(base + i);
        b.last = single || ((i % BL) == BL - 1);
        sb.push_back(b);
      end
    end
    update_fifo();
  endtask

  task automatic drain(input logic [3:0] pat, input bit gap_en, input int limit, output bit ok);
    int n;
    bit gap_done;
    n = 0;
    gap_done = 1'b0;
    m_ready = pat[0];
    while (sb.size() > 0 && n < limit) begin
      step();
      n++;
      if (gap_en && !gap_done && pops == 5) begin
        force_cnt = 3;
        gap_done = 1'b1;
        update_fifo();
      end
      m_ready = pat[n % 4];
    end
    ok = (sb.size() == 0);
  endtask

  // Stream monitor: sampled mid-cycle, a valid&&ready here is the handshake at the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    rd_seen = fifo_rd_en;
    if (mon_en) begin
      if (stall_prev) begin
        check(m_valid == 1'b1, "stall_valid_hold", int'(m_valid), 1);
        check(m_data == prev_data, "stall_data_hold", int'(m_data), int'(prev_data));
        check(m_last == prev_last, "stall_last_hold", int'(m_last), int'(prev_last));
      end
      if (m_valid && !m_ready)
        check(fifo_rd_en == 1'b0, "rd_en_while_stalled", int'(fifo_rd_en), 0);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check(sb.size() != 0, "unexpected_beat", int'(m_data), -1);
        end else begin
          e = sb.pop_front();
          check(m_data == e.data, "beat_data", int'(m_data), int'(e.data));
          check(m_last == e.last, "beat_last", int'(m_last), int'(e.last));
        end
        beats++;
        if (last_hs >= 0 && (cyc - last_hs) > max_gap) max_gap = cyc - last_hs;
        last_hs = cyc;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int seen;

    vecs[0] = '{nwords: 16, ready_pat: 4'b1111, gap_en: 1'b0, exp_bursts: 1, max_gap: 1};
    vecs[1] = '{nwords: 16, ready_pat: 4'b1001, gap_en: 1'b0, exp_bursts: 1, max_gap: 4};
    vecs[2] = '{nwords: 32, ready_pat: 4'b1111, gap_en: 1'b0, exp_bursts: 2, max_gap: 2};
    vecs[3] = '{nwords: 16, ready_pat: 4'b1111, gap_en: 1'b1, exp_bursts: 1, max_gap: 4};

    m_ready = 1'b0;
    update_fifo();

    for (int k = 0; k < 4; k++) begin
      do_reset();
      load(vecs[k].nwords, k * 32, 1'b0, 1'b1);
      drain(vecs[k].ready_pat, vecs[k].gap_en, 400, ok);
      check(ok, "drain_done", sb.size(), 0);
      check(busy == 1'b0, "busy_after_last", int'(busy), 0);
      check(int'(burst_cnt) == vecs[k].exp_bursts, "burst_cnt", int'(burst_cnt), vecs[k].exp_bursts);
      check(beats == vecs[k].nwords, "beat_count", beats, vecs[k].nwords);
      check(fq.size() == 0, "fifo_drained", fq.size(), 0);
      check(max_gap <= vecs[k].max_gap, "handshake_gap", max_gap, vecs[k].max_gap);
      $display("case %0d: words=%0d beats=%0d bursts=%0d max_gap=%0d", k, vecs[k].nwords, beats,
               burst_cnt, max_gap);
    end

    // Reset partway through the second burst.
    do_reset();
    load(16, 8'hA0, 1'b0, 1'b1);
    drain(4'b1111, 1'b0, 200, ok);
    check(burst_cnt == 16'd1, "pre_reset_burst_cnt", int'(burst_cnt), 1);
    load(16, 8'hB0, 1'b0, 1'b1);
    m_ready = 1'b1;
    n = 0;
    while (beats < 23 && n < 100) begin
      step();
      n++;
    end
    check(beats == 23, "reached_beat7", beats, 23);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check(m_valid == 1'b0, "async_rst_valid", int'(m_valid), 0);
    check(m_last == 1'b0, "async_rst_last", int'(m_last), 0);
    check(m_data == '0, "async_rst_data", int'(m_data), 0);
    check(burst_cnt == 16'd0, "async_rst_burst_cnt", int'(burst_cnt), 0);
    check(busy == 1'b0, "async_rst_busy", int'(busy), 0);
    check(fifo_rd_en == 1'b0, "async_rst_rd_en", int'(fifo_rd_en), 0);
    fq.delete();
    sb.delete();
    update_fifo();
    repeat (2) step();
    rst = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    load(16, 8'hC0, 1'b0, 1'b1);
    drain(4'b1111, 1'b0, 200, ok);
    check(ok, "post_reset_drain", sb.size(), 0);
    check(beats == 16, "post_reset_beats", beats, 16);
    check(burst_cnt == 16'd1, "post_reset_burst_cnt", int'(burst_cnt), 1);
    $display("reset mid-burst: post-reset beats=%0d bursts=%0d", beats, burst_cnt);

    // Residual words below the watermark.
    do_reset();
`ifdef FIFO_RD_TIMEOUT_EN
    load(3, 8'hE0, 1'b1, 1'b1);
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_valid) seen++;
    end
    check(seen == 0, "timeout_quiet", seen, 0);
    step();
    check(m_valid == 1'b1, "timeout_first_beat", int'(m_valid), 1);
    drain(4'b1111, 1'b0, 50, ok);
    check(ok, "flush_drain", sb.size(), 0);
    check(beats == 3, "flush_beats", beats, 3);
    check(burst_cnt == 16'd3, "flush_burst_cnt", int'(burst_cnt), 3);
    $display("timeout flush: beats=%0d bursts=%0d", beats, burst_cnt);
`else
    load(3, 8'hE0, 1'b0, 1'b0);
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_valid || fifo_rd_en) seen++;
    end
    check(seen == 0, "residual_no_output", seen, 0);
    check(fq.size() == 3, "residual_kept", fq.size(), 3);
    check(burst_cnt == 16'd0, "residual_burst_cnt", int'(burst_cnt), 0);
    $display("residual words: active_cycles=%0d words_left=%0d", seen, fq.size());
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
